// File: rtl/sd_digit_otf_converter_pkg.sv
// Shared definitions for the signed-digit on-the-fly converter.
// Holds the radix-2 digit codes used by the digit-selection block and the
// converter, plus the converter FSM state type.
package sd_digit_otf_converter_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } otf_state_t;

endpackage

// File: rtl/sd_otf_step.sv
// One radix-2 on-the-fly conversion step.
// Ports:
//   q, qm     current word Q and its companion QM = Q-1
//   digit     signed digit code (SD_POS/SD_NEG/SD_ZERO/SD_ILL)
//   q_next    Q after appending the digit
//   qm_next   QM after appending the digit (stays equal to q_next-1)
//   illegal   digit code was SD_ILL; the step then behaves as a zero digit
module sd_otf_step
  import sd_digit_otf_converter_pkg::*;
#(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next,
  output logic         illegal
);

  // Shifts drop the MSB: arithmetic is modulo 2^W.
  always_comb begin
    q_next  = W'({q, 1'b0});
    qm_next = W'({qm, 1'b1});
    illegal = 1'b0;
    case (digit)
      SD_POS: begin
        q_next  = W'({q, 1'b1});
        qm_next = W'({q, 1'b0});
      end
      SD_NEG: begin
        q_next  = W'({qm, 1'b1});
        qm_next = W'({qm, 1'b0});
      end
      SD_ILL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sd_digit_otf_converter.sv
// Signed-digit to two's-complement on-the-fly converter.
// Consumes DIGITS radix-2 digits (MSB first) and presents a DIGITS+1 bit
// two's-complement result through a valid/ack handshake.
// Ports:
//   clk, asyn_reset  clock, asynchronous active-high reset
//   start            begin a new conversion (any state, highest priority)
//   p_value          digit code; digit_valid consumes it while in CONVERT
//   result_ack       downstream accepts q_out while result_valid is high
//   digit_ready      registered: high while in CONVERT
//   q_out            last completed conversion result
//   result_valid     q_out holds an unacknowledged result
//   digit_err        sticky: an illegal digit code was consumed
module sd_digit_otf_converter
  import sd_digit_otf_converter_pkg::*;
#(
  parameter int DIGITS = 16,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic              start,
  input  logic [1:0]        p_value,
  input  logic              digit_valid,
  input  logic              result_ack,
  output logic              digit_ready,
  output logic [DIGITS:0]   q_out,
  output logic              result_valid,
  output logic              digit_err
);

  localparam int unsigned W = DIGITS + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  otf_state_t       state, state_next;
  logic [W-1:0]     q, qm, q_n, qm_n;
  logic [W-1:0]     step_q, step_qm;
  logic             step_ill;
  logic [CNT_W-1:0] count, count_n;
  logic [W-1:0]     q_out_n;
  logic             valid_n, err_n, ready_n;

  sd_otf_step #(.W(W)) u_step (
    .q       (q),
    .qm      (qm),
    .digit   (p_value),
    .q_next  (step_q),
    .qm_next (step_qm),
    .illegal (step_ill)
  );

  always_comb begin
    state_next = state;
    q_n        = q;
    qm_n       = qm;
    count_n    = count;
    q_out_n    = q_out;
    valid_n    = result_valid;
    err_n      = digit_err;
    if (start) begin
      state_next = CONVERT;
      q_n        = '0;
      qm_n       = '1;
      count_n    = '0;
      valid_n    = 1'b0;
      err_n      = 1'b0;
    end else begin
      case (state)
        CONVERT: begin
          if (digit_valid) begin
            q_n     = step_q;
            qm_n    = step_qm;
            count_n = count + CNT_W'(1);
            if (step_ill) err_n = 1'b1;
            if (count == LAST_CNT) begin
              q_out_n    = step_q;
              valid_n    = 1'b1;
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (result_ack) begin
            valid_n    = 1'b0;
            state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
    // digit_ready is registered from the next state, so it equals (state == CONVERT).
    ready_n = (state_next == CONVERT);
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state        <= IDLE;
      q            <= '0;
      qm           <= '1;
      count        <= '0;
      q_out        <= '0;
      result_valid <= 1'b0;
      digit_ready  <= 1'b0;
      digit_err    <= 1'b0;
    end else begin
      state        <= state_next;
      q            <= q_n;
      qm           <= qm_n;
      count        <= count_n;
      q_out        <= q_out_n;
      result_valid <= valid_n;
      digit_ready  <= ready_n;
      digit_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_sd_digit_otf_converter.sv
// Self-checking bench for sd_digit_otf_converter with DIGITS=4.
module tb_sd_digit_otf_converter;
  import sd_digit_otf_converter_pkg::*;

  localparam int DIGITS = 4;
  localparam int W      = DIGITS + 1;

  logic         clk = 1'b0;
  logic         asyn_reset;
  logic         start;
  logic [1:0]   p_value;
  logic         digit_valid;
  logic         result_ack;
  logic         digit_ready;
  logic [W-1:0] q_out;
  logic         result_valid;
  logic         digit_err;

  always #5 clk = ~clk;

  sd_digit_otf_converter #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .start        (start),
    .p_value      (p_value),
    .digit_valid  (digit_valid),
    .result_ack   (result_ack),
    .digit_ready  (digit_ready),
    .q_out        (q_out),
    .result_valid (result_valid),
    .digit_err    (digit_err)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] sb_q[$];
  int           mdl_val = 0;
  int           mdl_cnt = 0;
  bit           mdl_active = 1'b0;
  int           n_seen = 0;
  logic         rv_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: compare on each rising edge of result_valid.
  always @(negedge clk) begin
    if (asyn_reset) begin
      rv_prev = 1'b0;
    end else begin
      if (result_valid && !rv_prev) begin
        n_seen++;
        if (sb_q.size() == 0) check("sb_unexpected", sb_q.size(), 1);
        else check("sb_q_out", q_out, sb_q.pop_front());
      end
      rv_prev = result_valid;
    end
  end

  task automatic send(input logic [1:0] code, input int gap);
    int d;
    if (mdl_active) begin
      d = (code == SD_POS) ? 1 : (code == SD_NEG) ? -1 : 0;
      mdl_val = mdl_val * 2 + d;
      mdl_cnt++;
      if (mdl_cnt == DIGITS) begin
        sb_q.push_back(W'(mdl_val));
        mdl_active = 1'b0;
      end
    end
    p_value = code;
    digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    p_value = SD_ZERO;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mdl_active = 1'b1;
    mdl_cnt = 0;
    mdl_val = 0;
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t2 [4];
    t2[0] = SD_POS; t2[1] = SD_NEG; t2[2] = SD_ZERO; t2[3] = SD_NEG;

    asyn_reset = 1'b1; start = 1'b0; p_value = SD_ZERO;
    digit_valid = 1'b0; result_ack = 1'b0;
    #12;
    check("rst_q_out", q_out, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ready", digit_ready, 0);
    check("rst_err", digit_err, 0);
    @(negedge clk);
    asyn_reset = 1'b0;
    @(negedge clk);

    // +1,+1,+1,+1 back-to-back -> 15
    do_start();
    check("t1_ready", digit_ready, 1);
    repeat (3) send(SD_POS, 0);
    check("t1_no_early_valid", result_valid, 0);
    send(SD_POS, 0);
    check("t1_valid_latency", result_valid, 1);
    check("t1_ready_done", digit_ready, 0);
    do_ack();
    check("t1_ack_clears", result_valid, 0);
    check("t1_q_hold", q_out, 15);

    // +1,-1,0,-1 with gaps -> 3
    do_start();
    for (int i = 0; i < 3; i++) begin
      send(t2[i], 2);
      check("t2_ready_gap", digit_ready, 1);
    end
    send(t2[3], 0);
    check("t2_valid", result_valid, 1);
    do_ack();

    // -1 x4 -> -15, digits in DONE ignored
    do_start();
    repeat (4) send(SD_NEG, 0);
    send(SD_POS, 0);
    send(SD_ZERO, 0);
    check("t3_done_hold_q", q_out, 5'h11);
    check("t3_done_hold_valid", result_valid, 1);
    check("t3_done_ready", digit_ready, 0);
    do_ack();
    check("t3_ack_valid", result_valid, 0);
    check("t3_idle_ready", digit_ready, 0);
    send(SD_POS, 0);
    check("t3_idle_ignore_ready", digit_ready, 0);
    check("t3_idle_ignore_q", q_out, 5'h11);

    // start with a simultaneous digit drops that digit -> 1
    do_start();
    send(SD_POS, 0);
    send(SD_ZERO, 0);
    start = 1'b1; digit_valid = 1'b1; p_value = SD_POS;
    @(negedge clk);
    start = 1'b0; digit_valid = 1'b0; p_value = SD_ZERO;
    mdl_active = 1'b1; mdl_cnt = 0; mdl_val = 0;
    check("t4_restart_ready", digit_ready, 1);
    check("t4_restart_valid", result_valid, 0);
    send(SD_ZERO, 0);
    send(SD_ZERO, 0);
    send(SD_ZERO, 0);
    send(SD_POS, 0);
    do_ack();

    // illegal digit counts as zero and sets sticky error -> 4
    do_start();
    send(SD_ILL, 0);
    check("t5_err_set", digit_err, 1);
    send(SD_POS, 0);
    send(SD_ZERO, 0);
    check("t5_err_sticky", digit_err, 1);
    send(SD_ZERO, 0);
    check("t5_err_done", digit_err, 1);
    do_ack();
    do_start();
    check("t5_err_cleared", digit_err, 0);

    // asynchronous reset mid-conversion, then restart -> 11
    send(SD_POS, 0);
    send(SD_POS, 0);
    #2;
    asyn_reset = 1'b1;
    #1;
    check("t6_async_q_out", q_out, 0);
    check("t6_async_valid", result_valid, 0);
    check("t6_async_ready", digit_ready, 0);
    mdl_active = 1'b0;
    @(negedge clk);
    asyn_reset = 1'b0;
    @(negedge clk);
    do_start();
    send(SD_POS, 0);
    send(SD_POS, 0);
    send(SD_NEG, 0);
    send(SD_POS, 0);
    check("t6_valid", result_valid, 1);
    do_ack();

    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("sb_results_seen", n_seen, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_digit_otf_converter.md
Name: sd_digit_otf_converter

Overview:
- Consumer of the signed-digit quotient/result stream produced by the upper-bits control (digit-selection) logic.
- Accepts one radix-2 digit in {-1,0,+1} per enabled cycle and performs on-the-fly conversion into a conventional two's-complement word, with no final carry-propagate add.
- Sits at the output end of the online divide/sqrt datapath and hands the converted result downstream through a valid/ack handshake.

Parameters:
- DIGITS, 16, number of signed digits per conversion; the result is DIGITS+1 bits two's complement.
- CNT_W, $clog2(DIGITS+1), width of the digit counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- asyn_reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a new conversion; clears state; legal in any state.
- p_value  in  2  digit: 2'b10=+1, 2'b01=-1, 2'b00=0, 2'b11=illegal.
- digit_valid  in  1  p_value is consumed this cycle when the block is in CONVERT.
- result_ack  in  1  downstream accepts q_out; meaningful only while result_valid=1.
- digit_ready  out  1  high in CONVERT; digits offered at other times are dropped.
- q_out  out  DIGITS+1  converted value: integer sum of d_i*2^(DIGITS-1-i), with the first digit as the MSB.
- result_valid  out  1  q_out holds a completed conversion.
- digit_err  out  1  sticky; set when an illegal code is consumed.

Behaviour:
- Reset (async, asserted): state=IDLE, Q=0, QM=all ones, count=0, q_out=0, result_valid=0, digit_ready=0, digit_err=0. Reset mid-conversion discards all progress.
- FSM states: IDLE, CONVERT, DONE.
- IDLE: start -> CONVERT. All other inputs are ignored.
- On start, in any state and on the next edge: Q<=0, QM<=all ones (-1), count<=0, digit_err<=0, result_valid<=0, state<=CONVERT. start has priority over digit_valid and result_ack; a digit offered in the same cycle as start is discarded.
- CONVERT, digit_valid=1 consumes one digit, and Q/QM update on the same edge. Invariant: QM = Q-1.
  - +1: Q<={Q[DIGITS-1:0],1}, QM<={Q[DIGITS-1:0],0}.
  - 0: Q<={Q[DIGITS-1:0],0}, QM<={QM[DIGITS-1:0],1}.
  - -1: Q<={QM[DIGITS-1:0],1}, QM<={QM[DIGITS-1:0],0}.
  - 2'b11: treated as 0 and digit_err<=1.
  - count<=count+1.
- CONVERT, digit_valid=0: hold all state. Gaps between digits are unlimited.
- When a digit is consumed with count==DIGITS-1, that update is the final one:
  - on the same edge q_out<=next Q, result_valid<=1, state<=DONE;
  - latency from the last digit to result_valid is one cycle.
- DONE: q_out and result_valid hold until result_ack=1, then result_valid<=0 and state<=IDLE. digit_valid is ignored in DONE; digit_ready=0.
- q_out changes only on completion or reset. It is not cleared on ack and keeps its last value.
- Width rule: all shifts are modulo DIGITS+1 bits. The range ±(2^DIGITS-1) fits without overflow.
- digit_ready is a registered state decode, so it has no combinational path from the inputs.

Decomposition:
- Shared package holds:
  - digit encoding constants SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00, SD_ILL=2'b11, shared with the upper-bits control block;
  - the FSM state enum.
- One natural combinational sub-module: sd_otf_step. Inputs Q, QM, digit; outputs next Q, next QM and illegal flag. It is reusable for a radix-4 variant later.
- FSM, counter and handshake stay in the top module.

Test Plan (DIGITS=4):
- Digits +1,+1,+1,+1 back-to-back -> result_valid one cycle after the 4th digit; q_out=5'b01111 (15).
- Digits +1,-1,0,-1 with 2-cycle gaps between digits -> q_out=5'b00011 (3); digit_ready high throughout CONVERT.
- Digits -1,-1,-1,-1 -> q_out=5'b10001 (-15); then digits with result_ack=0 -> ignored, q_out held; ack -> IDLE.
- Digits +1,0 then start with digit_valid=1 and p_value=+1 in the same cycle -> that digit is dropped. Then 0,0,0,+1 -> q_out=1.
- Digits 11,+1,0,0 -> digit_err=1 and q_out=4 (illegal digit counts as 0). A following start clears digit_err.
- Assert asyn_reset asynchronously (mid-cycle) after 2 digits -> all outputs 0 immediately. Restart with +1,+1,-1,+1 -> q_out=11.
